// File: rtl/video_modes_pkg.sv
// Shared video mode definitions: timing parameter record, the supported mode
// table and the mode controller state encoding.
package video_modes_pkg;

  localparam int TIMING_W = 12;

  typedef struct packed {
    logic [TIMING_W-1:0] h_total;
    logic [TIMING_W-1:0] h_active;
    logic [TIMING_W-1:0] h_front_porch;
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] v_total;
    logic [TIMING_W-1:0] v_active;
    logic [TIMING_W-1:0] v_front_porch;
    logic [TIMING_W-1:0] v_sync;
    logic                h_sync_pol;
    logic                v_sync_pol;
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EOF,
    APPLY,
    MUTE,
    ACK
  } state_t;

  // 0: 640x480p60, 1: 720x480p60, 2: 1280x720p60, 3: 1920x1080p60
  localparam mode_t MODE_TABLE [4] = '{
    '{12'd800,  12'd640,  12'd16,  12'd96, 12'd525,  12'd480,  12'd10, 12'd2, 1'b0, 1'b0},
    '{12'd858,  12'd720,  12'd16,  12'd62, 12'd525,  12'd480,  12'd9,  12'd6, 1'b0, 1'b0},
    '{12'd1650, 12'd1280, 12'd110, 12'd40, 12'd750,  12'd720,  12'd5,  12'd5, 1'b1, 1'b1},
    '{12'd2200, 12'd1920, 12'd88,  12'd44, 12'd1125, 12'd1080, 12'd4,  12'd5, 1'b1, 1'b1}
  };

endpackage

// File: rtl/video_mode_ctrl_if.sv
// Mode-change request channel between a host and the video mode controller.
// 4-phase handshake: host raises mode_req with mode_sel stable; controller
// raises mode_ack when the mode is in effect; host drops mode_req; controller
// drops mode_ack; only then may the host raise mode_req again.
interface video_mode_ctrl_if;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;

  modport master (output mode_req, output mode_sel, input mode_ack);
  modport slave  (input mode_req, input mode_sel, output mode_ack);
endinterface

// File: rtl/video_mode_ctrl_frame_counter.sv
// Counts frame_end pulses while enabled; done flags the COUNT-th pulse in the
// same cycle and the count wraps so the counter is ready for the next run.
module frame_counter #(
  parameter int COUNT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic frame_end,
  output logic done
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'((COUNT > 0) ? COUNT - 1 : 0);

  logic [CW-1:0] count;

  assign done = enable && frame_end && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (enable && frame_end) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Video mode controller: accepts a mode request, applies it atomically at a
// frame boundary (or on timeout), mutes video for MUTE_FRAMES frames, then acks.
module video_mode_ctrl
  import video_modes_pkg::*;
#(
  parameter int MUTE_FRAMES  = 2,
  parameter int WAIT_TIMEOUT = 2_000_000
) (
  input  logic                clock,
  input  logic                reset,
  video_mode_ctrl_if.slave    req_bus,
  input  logic                frame_end,
  output logic                busy,
  output logic [1:0]          current_mode,
  output logic [TIMING_W-1:0] h_total,
  output logic [TIMING_W-1:0] h_active,
  output logic [TIMING_W-1:0] h_front_porch,
  output logic [TIMING_W-1:0] h_sync,
  output logic [TIMING_W-1:0] v_total,
  output logic [TIMING_W-1:0] v_active,
  output logic [TIMING_W-1:0] v_front_porch,
  output logic [TIMING_W-1:0] v_sync,
  output logic                h_sync_pol,
  output logic                v_sync_pol,
  output logic                timing_reset,
  output logic                video_mute,
  output state_t              dbg_state
);

  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(WAIT_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(WAIT_TIMEOUT);

  state_t        state;
  state_t        next_state;
  logic [1:0]    pending;
  logic          ack_owed;
  logic [TW-1:0] wait_count;
  mode_t         timing;
  logic          mute_tc;
  logic          mute_done;

  frame_counter #(.COUNT(MUTE_FRAMES)) u_frame_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (state == APPLY),
    .enable    (state == MUTE),
    .frame_end (frame_end),
    .done      (mute_tc)
  );

  // With no mute frames the MUTE state (entered from reset) is left at once.
  assign mute_done = (MUTE_FRAMES == 0) || mute_tc;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_bus.mode_req) begin
          next_state = (req_bus.mode_sel == current_mode) ? ACK : WAIT_EOF;
        end
      end
      WAIT_EOF: begin
        if (frame_end || (wait_count == T_LAST)) next_state = APPLY;
      end
      APPLY: begin
        next_state = (MUTE_FRAMES == 0) ? ACK : MUTE;
      end
      MUTE: begin
        if (mute_done) next_state = ack_owed ? ACK : IDLE;
      end
      ACK: begin
        if (!req_bus.mode_req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= MUTE;
      pending          <= 2'd0;
      ack_owed         <= 1'b0;
      wait_count       <= '0;
      timing           <= MODE_TABLE[0];
      current_mode     <= 2'd0;
      timing_reset     <= 1'b0;
      video_mute       <= 1'b1;
      busy             <= 1'b1;
      req_bus.mode_ack <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_bus.mode_req) begin
        pending  <= req_bus.mode_sel;
        ack_owed <= 1'b1;
      end else if (state == ACK) begin
        ack_owed <= 1'b0;
      end
      if (state == IDLE && next_state == WAIT_EOF) begin
        wait_count <= '0;
      end else if (wait_count != T_SAT) begin
        wait_count <= wait_count + 1'b1;
      end
      if (next_state == APPLY) begin
        timing       <= MODE_TABLE[pending];
        current_mode <= pending;
      end
      timing_reset     <= (next_state == APPLY);
      video_mute       <= (next_state == APPLY) || (next_state == MUTE);
      busy             <= (next_state != IDLE);
      req_bus.mode_ack <= (state == ACK);
    end
  end

  assign h_total       = timing.h_total;
  assign h_active      = timing.h_active;
  assign h_front_porch = timing.h_front_porch;
  assign h_sync        = timing.h_sync;
  assign v_total       = timing.v_total;
  assign v_active      = timing.v_active;
  assign v_front_porch = timing.v_front_porch;
  assign v_sync        = timing.v_sync;
  assign h_sync_pol    = timing.h_sync_pol;
  assign v_sync_pol    = timing.v_sync_pol;
  assign dbg_state     = state;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: one instance with two mute frames, one with none;
// a mode-table model predicts applied timing and acknowledged modes.
module tb_video_mode_ctrl;
  import video_modes_pkg::*;

  localparam int A_WT = 120;
  localparam int B_WT = 50;
  localparam int VW   = 100;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic frame_end = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   model_a   = 0;
  int   model_b   = 0;
  logic prev_ack  = 1'b0;
  logic [VW-1:0] apply_q[$];
  logic [VW-1:0] ack_q[$];

  int   ht[4] = '{800, 858, 1650, 2200};
  int   ha[4] = '{640, 720, 1280, 1920};
  int   hf[4] = '{16, 16, 110, 88};
  int   hs[4] = '{96, 62, 40, 44};
  int   vt[4] = '{525, 525, 750, 1125};
  int   va[4] = '{480, 480, 720, 1080};
  int   vf[4] = '{10, 9, 5, 4};
  int   vs[4] = '{2, 6, 5, 5};
  logic pos[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  video_mode_ctrl_if a_if();
  video_mode_ctrl_if b_if();

  logic a_busy, a_tr, a_mute, a_hp, a_vp;
  logic b_busy, b_tr, b_mute, b_hp, b_vp;
  logic [1:0]  a_cur, b_cur;
  logic [11:0] a_ht, a_ha, a_hf, a_hs, a_vt, a_va, a_vf, a_vs;
  logic [11:0] b_ht, b_ha, b_hf, b_hs, b_vt, b_va, b_vf, b_vs;
  state_t      a_st, b_st;
  logic [VW-1:0] a_vec, b_vec;

  assign a_vec = {a_cur, a_ht, a_ha, a_hf, a_hs, a_vt, a_va, a_vf, a_vs, a_hp, a_vp};
  assign b_vec = {b_cur, b_ht, b_ha, b_hf, b_hs, b_vt, b_va, b_vf, b_vs, b_hp, b_vp};

  video_mode_ctrl #(.MUTE_FRAMES(2), .WAIT_TIMEOUT(A_WT)) dut_a (
    .clock(clock), .reset(reset), .req_bus(a_if), .frame_end(frame_end),
    .busy(a_busy), .current_mode(a_cur),
    .h_total(a_ht), .h_active(a_ha), .h_front_porch(a_hf), .h_sync(a_hs),
    .v_total(a_vt), .v_active(a_va), .v_front_porch(a_vf), .v_sync(a_vs),
    .h_sync_pol(a_hp), .v_sync_pol(a_vp), .timing_reset(a_tr),
    .video_mute(a_mute), .dbg_state(a_st)
  );

  video_mode_ctrl #(.MUTE_FRAMES(0), .WAIT_TIMEOUT(B_WT)) dut_b (
    .clock(clock), .reset(reset), .req_bus(b_if), .frame_end(frame_end),
    .busy(b_busy), .current_mode(b_cur),
    .h_total(b_ht), .h_active(b_ha), .h_front_porch(b_hf), .h_sync(b_hs),
    .v_total(b_vt), .v_active(b_va), .v_front_porch(b_vf), .v_sync(b_vs),
    .h_sync_pol(b_hp), .v_sync_pol(b_vp), .timing_reset(b_tr),
    .video_mute(b_mute), .dbg_state(b_st)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] exp_vec(input int m);
    return {2'(m), 12'(ht[m]), 12'(ha[m]), 12'(hf[m]), 12'(hs[m]),
            12'(vt[m]), 12'(va[m]), 12'(vf[m]), 12'(vs[m]), pos[m], pos[m]};
  endfunction

  task automatic check_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic report_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  // Monitor: every timing_reset pulse and every ack rise consumes one expectation.
  always @(negedge clock) begin
    if (a_tr) begin
      if (apply_q.size() == 0) report_event("apply_unexpected");
      else check_v("apply_values", a_vec, apply_q.pop_front());
    end
    if (a_if.mode_ack && !prev_ack) begin
      if (ack_q.size() == 0) report_event("ack_unexpected");
      else check_v("ack_mode", a_vec, ack_q.pop_front());
    end
    prev_ack <= a_if.mode_ack;
  end

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
  endtask

  task automatic a_post_reset_mute();
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clock);
      check_b("a_reset_mute_held", a_mute, 1'b1);
      pulse_frame_end();
    end
    check_b("a_reset_mute_released", a_mute, 1'b0);
    check_b("a_reset_idle", a_busy, 1'b0);
    repeat (3) @(negedge clock);
    check_b("a_reset_no_ack", a_if.mode_ack, 1'b0);
  endtask

  task automatic a_request(input int sel, input int fe_delay, input int hold,
                           input logic fe_in_apply, input logic reset_in_mute);
    int   n;
    int   exp_at;
    int   exp_ack;
    logic same;
    same = (sel == model_a);
    ack_q.push_back(exp_vec(sel));
    if (!same) apply_q.push_back(exp_vec(sel));
    a_if.mode_req = 1'b1;
    a_if.mode_sel = 2'(sel);
    @(negedge clock);
    check_b("a_busy_on_accept", a_busy, 1'b1);
    if (same) begin
      exp_ack = 0;
      @(negedge clock);
      check_b("a_same_ack", a_if.mode_ack, 1'b1);
      check_b("a_same_no_reset", a_tr, 1'b0);
      check_b("a_same_no_mute", a_mute, 1'b0);
    end else begin
      exp_ack = 1;
      exp_at = (fe_delay < 0) ? A_WT : fe_delay + 1;
      n = 0;
      while (!a_tr && n < A_WT + 5) begin
        frame_end = (n == fe_delay);
        a_if.mode_sel = 2'($urandom_range(0, 3));
        @(negedge clock);
        n++;
      end
      check_i("a_apply_latency", n, exp_at);
      frame_end = fe_in_apply;
      @(negedge clock);
      frame_end = 1'b0;
      check_b("a_reset_pulse_width", a_tr, 1'b0);
      check_b("a_mute_after_apply", a_mute, 1'b1);
      if (reset_in_mute) begin
        #2 reset = 1'b1;
        a_if.mode_req = 1'b0;
        #1 check_v("a_async_reset_vals", a_vec, exp_vec(0));
        check_b("a_async_reset_mute", a_mute, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        ack_q.delete();
        apply_q.delete();
        model_a = 0;
        model_b = 0;
        a_post_reset_mute();
        return;
      end
      for (int i = 0; i < 2; i++) begin
        repeat ($urandom_range(1, 5)) @(negedge clock);
        check_b("a_mute_held", a_mute, 1'b1);
        pulse_frame_end();
      end
      check_b("a_mute_released", a_mute, 1'b0);
      check_b("a_ack_not_early", a_if.mode_ack, 1'b0);
    end
    n = 0;
    while (!a_if.mode_ack && n < 10) begin
      @(negedge clock);
      n++;
    end
    check_i("a_ack_latency", n, exp_ack);
    repeat (hold) begin
      a_if.mode_sel = 2'($urandom_range(0, 3));
      @(negedge clock);
      check_b("a_ack_held", a_if.mode_ack, 1'b1);
      check_b("a_no_second_txn", a_tr, 1'b0);
    end
    a_if.mode_req = 1'b0;
    @(negedge clock);
    check_b("a_ack_until_req_low", a_if.mode_ack, 1'b1);
    check_b("a_idle_after_ack", a_busy, 1'b0);
    @(negedge clock);
    check_b("a_ack_fall", a_if.mode_ack, 1'b0);
    model_a = sel;
  endtask

  task automatic b_request(input int sel, input int fe_delay);
    int n;
    int exp_at;
    b_if.mode_req = 1'b1;
    b_if.mode_sel = 2'(sel);
    @(negedge clock);
    exp_at = (fe_delay < 0) ? B_WT : fe_delay + 1;
    n = 0;
    while (!b_tr && n < B_WT + 5) begin
      frame_end = (n == fe_delay);
      b_if.mode_sel = 2'($urandom_range(0, 3));
      @(negedge clock);
      n++;
    end
    frame_end = 1'b0;
    check_i("b_apply_latency", n, exp_at);
    check_v("b_apply_vals", b_vec, exp_vec(sel));
    check_i("b_apply_state", int'(b_st), int'(APPLY));
    check_b("b_mute_in_apply", b_mute, 1'b1);
    @(negedge clock);
    check_b("b_reset_pulse_width", b_tr, 1'b0);
    check_b("b_mute_one_cycle", b_mute, 1'b0);
    @(negedge clock);
    check_b("b_ack", b_if.mode_ack, 1'b1);
    b_if.mode_req = 1'b0;
    repeat (2) @(negedge clock);
    check_b("b_ack_fall", b_if.mode_ack, 1'b0);
    model_b = sel;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    a_if.mode_req = 1'b0;
    a_if.mode_sel = 2'd0;
    b_if.mode_req = 1'b0;
    b_if.mode_sel = 2'd0;
    repeat (3) @(negedge clock);
    check_v("reset_timing", a_vec, exp_vec(0));
    check_b("reset_mute", a_mute, 1'b1);
    check_b("reset_busy", a_busy, 1'b1);
    check_b("reset_ack", a_if.mode_ack, 1'b0);
    check_b("reset_timing_reset", a_tr, 1'b0);
    check_i("reset_state", int'(a_st), int'(MUTE));
    reset = 1'b0;
    a_post_reset_mute();
    check_b("b_idle_after_reset", b_busy, 1'b0);
    check_v("b_reset_timing", b_vec, exp_vec(0));

    a_request(2, 99, 0, 1'b0, 1'b0);
    a_request(2, 0, 3, 1'b0, 1'b0);
    a_request(3, -1, 0, 1'b1, 1'b0);
    a_request(1, 20, 10, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 3);
      a_request(sel, ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 100),
                $urandom_range(0, 10), 1'(($urandom_range(0, 1))), 1'b0);
    end

    b_request(3, -1);
    b_request(1, 7);

    a_request((model_a + 1) % 4, 10, 0, 1'b0, 1'b1);
    check_v("b_after_async_reset", b_vec, exp_vec(0));
    a_request(2, 5, 2, 1'b0, 1'b0);

    check_i("apply_q_drained", apply_q.size(), 0);
    check_i("ack_q_drained", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Mode controller for the video timing generator. It accepts mode-change requests over a 4-phase req/ack handshake and holds the new mode until a frame boundary. At that boundary it loads the generator's timing parameters atomically and restarts the generator's counters. It then mutes video for a programmable number of frames before acknowledging, so the sink never sees a torn frame.

## Interface
- MUTE_FRAMES, 2: whole frames with `video_mute` held high after a mode is applied (0 allowed).
- WAIT_TIMEOUT, 2_000_000: clock cycles to wait for `frame_end` before applying anyway (≥1).
- clock  in  1  pixel clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- mode_req  in  1  request; 4-phase handshake with `mode_ack`.
- mode_sel  in  2  requested mode index; sampled only when a request is accepted.
- frame_end  in  1  one-cycle pulse from the timing generator on the last pixel of a frame.
- mode_ack  out  1  request complete; high until `mode_req` falls.
- busy  out  1  high in every state except IDLE.
- current_mode  out  2  index of the mode currently driven.
- h_total, h_active, h_front_porch, h_sync  out  12 each  horizontal timing, in pixels.
- v_total, v_active, v_front_porch, v_sync  out  12 each  vertical timing, in lines.
- h_sync_pol, v_sync_pol  out  1 each  1 = positive sync.
- timing_reset  out  1  one-cycle pulse; the generator clears its X/Y counters.
- video_mute  out  1  high: the generator forces DE low and RGB to 0.

## Operation
- Mode table, 3-bit index not needed (2 bits):
  - 0 = 640x480p60: 800/640/16/96, 525/480/10/2, neg/neg.
  - 1 = 720x480p60: 858/720/16/62, 525/480/9/6, neg/neg.
  - 2 = 1280x720p60: 1650/1280/110/40, 750/720/5/5, pos/pos.
  - 3 = 1920x1080p60: 2200/1920/88/44, 1125/1080/4/5, pos/pos.
- States: IDLE, WAIT_EOF, APPLY, MUTE, ACK.
- IDLE: when `mode_req`=1, latch `mode_sel` into `pending` and set `ack_owed`.
  - If `pending` == `current_mode`, go to ACK (no reload, no mute).
  - Otherwise go to WAIT_EOF and clear the timeout counter.
- WAIT_EOF: on `frame_end`, or when the timeout counter reaches WAIT_TIMEOUT−1, go to APPLY. The counter is `$clog2(WAIT_TIMEOUT+1)` bits and saturates.
- APPLY (exactly 1 cycle):
  - Timing outputs and `current_mode` take the `pending` entry.
  - `timing_reset`=1 and `video_mute`=1.
  - Frame counter cleared.
  - Next state: MUTE, or ACK if MUTE_FRAMES=0.
- MUTE: count `frame_end` pulses. After the MUTE_FRAMES-th pulse, go to ACK if `ack_owed`, else IDLE.
- ACK: `mode_ack`=1 and `ack_owed` cleared. Return to IDLE once `mode_req`=0.
- `mode_sel` and `mode_req` are ignored outside IDLE, except that ACK watches `mode_req` falling.

## Timing
- All outputs are registered.
- Reset values:
  - state = MUTE, `ack_owed`=0, `current_mode`=0.
  - Timing outputs = mode 0.
  - `video_mute`=1, `timing_reset`=0, `mode_ack`=0, `busy`=1.
- After reset, the block mutes MUTE_FRAMES frames and then enters IDLE without acknowledging.
- Request latency: `mode_req` seen at edge t puts the block in WAIT_EOF (or ACK) after edge t.
- Apply latency: `frame_end` sampled at edge k puts the block in APPLY for the cycle after edge k.
  - New timing values and `timing_reset` are visible in that same cycle.
  - MUTE (or ACK) follows after edge k+1.
- `video_mute` is 1 in APPLY and MUTE and 0 elsewhere, so the mute length is MUTE_FRAMES whole frames.
- A `frame_end` arriving during the APPLY cycle is ignored, because the generator is being reset.
- `mode_ack` rises one cycle after entering ACK. It falls on the edge after `mode_req`=0 is sampled.
- A new request is accepted no earlier than the cycle after ACK exits; `mode_req` must have been low for at least one cycle.
- Asynchronous reset mid-operation:
  - A pending mode is discarded.
  - Outputs return to mode 0 immediately.
  - The mute sequence restarts.
- Timeout: with no `frame_end`, APPLY occurs WAIT_TIMEOUT cycles after entering WAIT_EOF.

## Structure
- Shared package `video_modes_pkg`:
  - `mode_t` struct with the eight 12-bit fields and two polarity bits.
  - `MODE_TABLE[4]` constant.
  - `state_t` enum.
  - `TIMING_W=12`.
- The timing generator also imports this package.
- One sub-module, `frame_counter`: counts `frame_end` pulses, with clear and a terminal-count output. It is reused by the generator's pattern sequencer.

## Test plan
- **Reset:** assert `reset` for 3 cycles, MUTE_FRAMES=2.
  - Outputs 800/640/16/96/525/480/10/2, neg/neg, `video_mute`=1.
  - `video_mute` falls after the 2nd `frame_end`; `mode_ack` is never raised.
- **Mode change:** request mode 2 in IDLE, `frame_end` 100 cycles later.
  - APPLY the next cycle: `h_total`=1650, `v_total`=750, pos/pos, `timing_reset` high for exactly 1 cycle.
  - `mode_ack` after 2 further `frame_end` pulses.
- **Same mode:** request `mode_sel`=`current_mode`.
  - ACK within 2 cycles; `timing_reset` stays 0 and `video_mute` stays 0.
- **Timeout:** WAIT_TIMEOUT=50, request mode 3, no `frame_end`.
  - APPLY exactly 50 cycles after entering WAIT_EOF; `h_total`=2200.
- **Handshake:** hold `mode_req` high 10 cycles after ack and toggle `mode_sel` during WAIT_EOF and ACK.
  - `mode_ack` stays high until `mode_req` falls.
  - The applied mode is the one latched at acceptance.
  - No second transaction starts.
- **Corner cases:**
  - MUTE_FRAMES=0: APPLY goes straight to ACK with mute lasting 1 cycle.
  - Reset asserted in MUTE: outputs return to mode 0 asynchronously.
